// File: rtl/queue_pkg.sv
// Shared definitions for the queue controller: state encoding and default address width.
package queue_pkg;

    localparam int unsigned DEFAULT_NUM_OF_BIT = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b01,
        FULL   = 2'b10
    } queue_state_e;

endpackage

// File: rtl/queue_ptr.sv
// Wrapping up-counter used as a queue pointer; one extra MSB distinguishes full from empty.
module queue_ptr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Clear,
    output logic [WIDTH-1:0] Value
);

    localparam logic [WIDTH-1:0] PTR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] ptr_r;

    // Pointer register: clear wins over increment; increment wraps naturally.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr_r <= {WIDTH{1'b0}};
        end else if (Clear) begin
            ptr_r <= {WIDTH{1'b0}};
        end else if (Enable) begin
            ptr_r <= ptr_r + PTR_ONE;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign Value = ptr_r;

endmodule

// File: rtl/queue_ctrl.sv
// Queue controller: pointer, occupancy and error-flag management for an external storage array.
module queue_ctrl
    import queue_pkg::*;
#(
    parameter int unsigned numOfBit = DEFAULT_NUM_OF_BIT
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                WriteReq,
    input  logic                ReadReq,
    input  logic                Flush,
    output logic                WriteEn,
    output logic [numOfBit-1:0] WriteAddr,
    output logic                ReadEn,
    output logic [numOfBit-1:0] ReadAddr,
    output logic                Full,
    output logic                Empty,
    output logic [numOfBit:0]   Count,
    output logic                Overflow,
    output logic                Underflow
);

    localparam logic [numOfBit:0] CNT_ZERO = {(numOfBit+1){1'b0}};
    localparam logic [numOfBit:0] CNT_ONE  = {{numOfBit{1'b0}}, 1'b1};
    localparam logic [numOfBit:0] CNT_LAST = {1'b0, {numOfBit{1'b1}}};

    queue_state_e      state_r;
    queue_state_e      next_state_s;
    logic [numOfBit:0] count_r;
    logic [numOfBit:0] count_next_s;
    logic              overflow_r;
    logic              overflow_next_s;
    logic              underflow_r;
    logic              underflow_next_s;
    logic              empty_s;
    logic              full_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [numOfBit:0] wptr_s;
    logic [numOfBit:0] rptr_s;

    assign empty_s = (state_r == EMPTY);
    assign full_s  = (state_r == FULL);

    // Reset gating keeps strobes quiet while Reset is held low.
    assign wr_acc_s = WriteReq & ~full_s  & ~Flush & Reset;
    assign rd_acc_s = ReadReq  & ~empty_s & ~Flush & Reset;

    queue_ptr #(.WIDTH(numOfBit + 1)) u_wptr (
        .CLK    (CLK),
        .Reset  (Reset),
        .Enable (wr_acc_s),
        .Clear  (Flush),
        .Value  (wptr_s)
    );

    queue_ptr #(.WIDTH(numOfBit + 1)) u_rptr (
        .CLK    (CLK),
        .Reset  (Reset),
        .Enable (rd_acc_s),
        .Clear  (Flush),
        .Value  (rptr_s)
    );

    // Next-state decode for the occupancy FSM.
    always_comb begin
        next_state_s = state_r;
        if (Flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (wr_acc_s) begin
                        next_state_s = ACTIVE;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                ACTIVE: begin
                    if (wr_acc_s && !rd_acc_s && (count_r == CNT_LAST)) begin
                        next_state_s = FULL;
                    end else if (rd_acc_s && !wr_acc_s && (count_r == CNT_ONE)) begin
                        next_state_s = EMPTY;
                    end else begin
                        next_state_s = ACTIVE;
                    end
                end
                FULL: begin
                    if (rd_acc_s) begin
                        next_state_s = ACTIVE;
                    end else begin
                        next_state_s = FULL;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                end
            endcase
        end
    end

    // Next occupancy count and sticky error flags.
    always_comb begin
        count_next_s     = count_r;
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;
        if (Flush) begin
            count_next_s     = CNT_ZERO;
            overflow_next_s  = 1'b0;
            underflow_next_s = 1'b0;
        end else begin
            if (wr_acc_s && !rd_acc_s) begin
                count_next_s = count_r + CNT_ONE;
            end else if (rd_acc_s && !wr_acc_s) begin
                count_next_s = count_r - CNT_ONE;
            end else begin
                count_next_s = count_r;
            end
            overflow_next_s  = overflow_r  | (WriteReq & full_s);
            underflow_next_s = underflow_r | (ReadReq & empty_s);
        end
    end

    // State, count and flag registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r     <= EMPTY;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            count_r     <= count_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    assign WriteEn   = wr_acc_s;
    assign ReadEn    = rd_acc_s;
    assign WriteAddr = wptr_s[numOfBit-1:0];
    assign ReadAddr  = rptr_s[numOfBit-1:0];
    assign Full      = full_s;
    assign Empty     = empty_s;
    assign Count     = count_r;
    assign Overflow  = overflow_r;
    assign Underflow = underflow_r;

endmodule

// File: tb/tb_queue_ctrl.sv
// Self-checking bench for queue_ctrl at numOfBit=3 using address scoreboards.
module tb_queue_ctrl;

    localparam int NB = 3;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          WriteReq, ReadReq, Flush;
    logic          WriteEn, ReadEn, Full, Empty, Overflow, Underflow;
    logic [NB-1:0] WriteAddr, ReadAddr;
    logic [NB:0]   Count;

    int total = 0;
    int bad   = 0;

    logic [NB-1:0] exp_wq[$];
    logic [NB-1:0] exp_rq[$];
    logic [NB-1:0] m_wa;
    logic [NB-1:0] m_ra;

    queue_ctrl #(.numOfBit(NB)) dut (
        .CLK(CLK), .Reset(Reset), .WriteReq(WriteReq), .ReadReq(ReadReq), .Flush(Flush),
        .WriteEn(WriteEn), .WriteAddr(WriteAddr), .ReadEn(ReadEn), .ReadAddr(ReadAddr),
        .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic w, input logic r, input logic f);
        @(negedge CLK);
        WriteReq = w;
        ReadReq  = r;
        Flush    = f;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One accepted-write step: push expected address, check strobe and popped address.
    task automatic sb_write(input string tag);
        logic [NB-1:0] e;
        exp_wq.push_back(m_wa);
        m_wa = m_wa + 3'd1;
        total++;
        if (WriteEn !== 1'b1) begin
            bad++;
            $display("FAIL %s_wen got=%b exp=1", tag, WriteEn);
        end else begin
            e = exp_wq.pop_front();
            total++;
            if (WriteAddr !== e) begin
                bad++;
                $display("FAIL %s_waddr got=%0d exp=%0d", tag, WriteAddr, e);
            end
        end
    endtask

    task automatic sb_read(input string tag);
        logic [NB-1:0] e;
        exp_rq.push_back(m_ra);
        m_ra = m_ra + 3'd1;
        total++;
        if (ReadEn !== 1'b1) begin
            bad++;
            $display("FAIL %s_ren got=%b exp=1", tag, ReadEn);
        end else begin
            e = exp_rq.pop_front();
            total++;
            if (ReadAddr !== e) begin
                bad++;
                $display("FAIL %s_raddr got=%0d exp=%0d", tag, ReadAddr, e);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; WriteReq = 1'b1; ReadReq = 1'b0; Flush = 1'b0;
        m_wa = 3'd0; m_ra = 3'd0;
        #3;
        total++; if (Empty !== 1'b1)  begin bad++; $display("FAIL rst_empty got=%b exp=1", Empty); end
        total++; if (Full !== 1'b0)   begin bad++; $display("FAIL rst_full got=%b exp=0", Full); end
        total++; if (Count !== 4'd0)  begin bad++; $display("FAIL rst_count got=%0d exp=0", Count); end
        total++; if (WriteEn !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b exp=0", WriteEn); end
        total++; if (WriteAddr !== 3'd0 || ReadAddr !== 3'd0) begin
            bad++; $display("FAIL rst_addr got=%0d/%0d exp=0/0", WriteAddr, ReadAddr);
        end
        tick();
        total++; if (Count !== 4'd0) begin bad++; $display("FAIL rst_hold_count got=%0d exp=0", Count); end
        @(negedge CLK);
        WriteReq = 1'b0;
        Reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            sb_write("fill");
            tick();
            total++;
            if (Count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", Count, i + 1); end
        end
        total++; if (Full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", Full); end
        drive(1'b1, 1'b0, 1'b0);
        total++; if (WriteEn !== 1'b0) begin bad++; $display("FAIL ovf_wen got=%b exp=0", WriteEn); end
        tick();
        total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Overflow); end
        total++; if (Count !== 4'd8 || WriteAddr !== 3'd0) begin
            bad++; $display("FAIL ovf_hold got=%0d/%0d exp=8/0", Count, WriteAddr);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            sb_read("drain");
            total++; if (Empty !== 1'b0) begin bad++; $display("FAIL drain_empty_early got=%b exp=0", Empty); end
            tick();
        end
        total++; if (Empty !== 1'b1 || Count !== 4'd0) begin
            bad++; $display("FAIL drain_empty got=%b/%0d exp=1/0", Empty, Count);
        end
        drive(1'b0, 1'b1, 1'b0);
        total++; if (ReadEn !== 1'b0) begin bad++; $display("FAIL unf_ren got=%b exp=0", ReadEn); end
        tick();
        total++; if (Underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", Underflow); end
        // Read on empty together with a write: write still accepted at wrapped address 0.
        drive(1'b1, 1'b1, 1'b0);
        total++; if (ReadEn !== 1'b0) begin bad++; $display("FAIL wrap_ren got=%b exp=0", ReadEn); end
        total++; if (WriteAddr !== 3'd0) begin bad++; $display("FAIL wrap_waddr got=%0d exp=0", WriteAddr); end
        sb_write("wrap");
        tick();
        total++; if (Count !== 4'd1 || Overflow !== 1'b1 || Underflow !== 1'b1) begin
            bad++; $display("FAIL wrap_state got=%0d/%b/%b exp=1/1/1", Count, Overflow, Underflow);
        end
        drive(1'b0, 1'b0, 1'b1);
        tick();
        m_wa = 3'd0; m_ra = 3'd0;
        total++; if (Count !== 4'd0 || Overflow !== 1'b0 || Underflow !== 1'b0 || Empty !== 1'b1) begin
            bad++; $display("FAIL clr_state got=%0d/%b/%b/%b exp=0/0/0/1", Count, Overflow, Underflow, Empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            sb_write("pre");
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            sb_write("b2b");
            sb_read("b2b");
            tick();
            total++; if (Count !== 4'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", Count); end
        end
        total++; if (WriteAddr !== 3'd6 || ReadAddr !== 3'd2) begin
            bad++; $display("FAIL b2b_final got=%0d/%0d exp=6/2", WriteAddr, ReadAddr);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            sb_write("top");
            tick();
        end
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            sb_read("part");
            tick();
        end
        total++; if (Count !== 4'd5 || Overflow !== 1'b1) begin
            bad++; $display("FAIL pre_flush got=%0d/%b exp=5/1", Count, Overflow);
        end
        drive(1'b1, 1'b1, 1'b1);
        total++; if (WriteEn !== 1'b0 || ReadEn !== 1'b0) begin
            bad++; $display("FAIL flush_strobes got=%b/%b exp=0/0", WriteEn, ReadEn);
        end
        tick();
        m_wa = 3'd0; m_ra = 3'd0;
        total++; if (Count !== 4'd0 || Empty !== 1'b1 || Overflow !== 1'b0) begin
            bad++; $display("FAIL flush_state got=%0d/%b/%b exp=0/1/0", Count, Empty, Overflow);
        end
        total++; if (WriteAddr !== 3'd0 || ReadAddr !== 3'd0) begin
            bad++; $display("FAIL flush_addr got=%0d/%0d exp=0/0", WriteAddr, ReadAddr);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            sb_write("fill6");
            tick();
        end
        total++; if (Count !== 4'd6) begin bad++; $display("FAIL pre_rst got=%0d exp=6", Count); end
        #2;
        Reset = 1'b0;
        #1;
        total++; if (Count !== 4'd0 || Empty !== 1'b1) begin
            bad++; $display("FAIL async_rst got=%0d/%b exp=0/1", Count, Empty);
        end
        total++; if (WriteEn !== 1'b0 || WriteAddr !== 3'd0) begin
            bad++; $display("FAIL async_rst_wr got=%b/%0d exp=0/0", WriteEn, WriteAddr);
        end
        @(negedge CLK);
        Reset = 1'b1;
        m_wa = 3'd0; m_ra = 3'd0;
        #1;
        sb_write("resume");
        tick();
        total++; if (Count !== 4'd1 || Empty !== 1'b0) begin
            bad++; $display("FAIL resume got=%0d/%b exp=1/0", Count, Empty);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        total++;
        if (exp_wq.size() != 0 || exp_rq.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d/%0d exp=0/0", exp_wq.size(), exp_rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
